// File: rtl/mux_8x1_if.sv
// mux_8x1_if: lane bundle, select and registered result for the 8:1 selector
interface mux_8x1_if #(
    parameter int WIDTH = 1
);
    logic [8*WIDTH-1:0] in;
    logic [2:0]         sel;
    logic [WIDTH-1:0]   y;
    modport master (output in, output sel, input y);
    modport slave (input in, input sel, output y);
endinterface

// File: rtl/mux_8x1.sv
// mux_8x1: registered 8:1 lane selector built from a three-level tree of 2:1 cells
module mux_2x1 #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             s_i,
    output logic [WIDTH-1:0] y_o
);
    always_comb y_o = s_i ? b_i : a_i;
endmodule

module mux_8x1 #(
    parameter int WIDTH = 1
) (
    input logic      clk,
    input logic      rst,
    mux_8x1_if.slave bus
);
    logic [3:0][WIDTH-1:0] l1_w;
    logic [1:0][WIDTH-1:0] l2_w;
    logic [WIDTH-1:0]      y_d;
    logic [WIDTH-1:0]      y_q;
    for (genvar i = 0; i < 4; i++) begin : g_l1
        mux_2x1 #(.WIDTH(WIDTH)) u_cell (
            .a_i(bus.in[2*i*WIDTH +: WIDTH]),
            .b_i(bus.in[(2*i+1)*WIDTH +: WIDTH]),
            .s_i(bus.sel[0]),
            .y_o(l1_w[i])
        );
    end
    for (genvar i = 0; i < 2; i++) begin : g_l2
        mux_2x1 #(.WIDTH(WIDTH)) u_cell (
            .a_i(l1_w[2*i]),
            .b_i(l1_w[2*i+1]),
            .s_i(bus.sel[1]),
            .y_o(l2_w[i])
        );
    end
    mux_2x1 #(.WIDTH(WIDTH)) u_l3 (
        .a_i(l2_w[0]),
        .b_i(l2_w[1]),
        .s_i(bus.sel[2]),
        .y_o(y_d)
    );
    always_ff @(posedge clk) begin
        if (rst) y_q <= '0;
        else     y_q <= y_d;
    end
    assign bus.y = y_q;
endmodule

// File: tb/tb_mux_8x1.sv
// tb_mux_8x1: table-driven and hand-sequenced checks of the registered 8:1 selector
module tb_mux_8x1;
    typedef struct {
        logic       rst;
        logic [7:0] in;
        logic [2:0] sel;
        logic       exp;
        string      nm;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;
    vec_t vq[$];

    mux_8x1_if #(.WIDTH(1)) b1 ();
    mux_8x1_if #(.WIDTH(8)) b8 ();

    mux_8x1 #(.WIDTH(1)) u_w1 (.clk(clk), .rst(rst), .bus(b1.slave));
    mux_8x1 #(.WIDTH(8)) u_w8 (.clk(clk), .rst(rst), .bus(b8.slave));

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [7:0] i, input logic [2:0] s, input logic e, input string nm);
        vec_t v;
        v.rst = r;
        v.in = i;
        v.sel = s;
        v.exp = e;
        v.nm = nm;
        vq.push_back(v);
    endtask

    task automatic edge_then_sample();
        @(posedge clk);
        #1;
    endtask

    logic       sweep_exp [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] l8;

    initial begin
        add(1'b1, 8'hFF, 3'd3, 1'b0, "rst_edge0");
        add(1'b1, 8'hFF, 3'd3, 1'b0, "rst_edge1");
        add(1'b0, 8'hFF, 3'd3, 1'b1, "rst_release");
        for (int s = 0; s < 8; s++) add(1'b0, 8'b10100111, 3'(s), sweep_exp[s], $sformatf("sweep_sel%0d", s));
        for (int s = 0; s < 6; s++) add(1'b0, 8'b10100111, 3'(s), sweep_exp[s], $sformatf("mid_sel%0d", s));
        add(1'b1, 8'b10100111, 3'd6, 1'b0, "mid_rst");
        add(1'b0, 8'b10100111, 3'd7, 1'b1, "mid_resume");
        for (int k = 0; k < 8; k++) begin
            add(1'b0, 8'(1 << k), 3'(k), 1'b1, $sformatf("walk_hit%0d", k));
            add(1'b0, 8'(1 << k), 3'((k + 1) % 8), 1'b0, $sformatf("walk_miss%0d", k));
        end

        b8.in = '1;
        b8.sel = 3'd2;
        foreach (vq[n]) begin
            @(negedge clk);
            rst = vq[n].rst;
            b1.in = vq[n].in;
            b1.sel = vq[n].sel;
            edge_then_sample();
            check(vq[n].nm, 64'(b1.y), 64'(vq[n].exp));
            if (vq[n].rst) check({vq[n].nm, "_w8"}, 64'(b8.y), 64'h0);
        end

        @(negedge clk);
        rst = 1'b0;
        b1.in = 8'h00;
        b1.sel = 3'd5;
        edge_then_sample();
        check("lat_base", 64'(b1.y), 64'h0);
        #1 b1.in[5] = 1'b1;
        #1 check("lat_no_comb_in", 64'(b1.y), 64'h0);
        edge_then_sample();
        check("lat_after_edge", 64'(b1.y), 64'h1);
        b1.in[4] = 1'b1;
        edge_then_sample();
        check("lat_in4_set", 64'(b1.y), 64'h1);
        b1.in[4] = 1'b0;
        edge_then_sample();
        check("lat_in4_clr", 64'(b1.y), 64'h1);
        b1.sel = 3'd4;
        #1 check("lat_no_comb_sel", 64'(b1.y), 64'h1);
        edge_then_sample();
        check("lat_sel_edge", 64'(b1.y), 64'h0);

        for (int n = 0; n < 8; n++) begin
            l8 = 8'(16 * (n + 1) + n);
            b8.in[n*8 +: 8] = l8;
        end
        for (int s = 7; s >= 0; s--) begin
            @(negedge clk);
            b8.sel = 3'(s);
            edge_then_sample();
            l8 = {4'(s + 1), 4'(s)};
            check($sformatf("w8_sel%0d", s), 64'(b8.y), 64'(l8));
        end
        @(negedge clk);
        b8.in[3*8 +: 8] = 8'hC3;
        b8.sel = 3'd3;
        edge_then_sample();
        check("w8_simul_change", 64'(b8.y), 64'hC3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
